// File: rtl/accum_offset_walker_pkg.sv
// ---------------------------------------------------------------------------
// TauCfg: shared configuration for the accumulation offset walker.
//   VDIM     - default number of walked dimensions
//   WORK_BW  - default offset width (unsigned)
//   ICFG_BW  - default width of the beg/end config indices
//   ofs_vec_t - packed VDIM x WORK_BW offset vector; element 0 is the
//               outermost dimension, element VDIM-1 the innermost.
// ---------------------------------------------------------------------------
package TauCfg;

  localparam int VDIM    = 2;
  localparam int WORK_BW = 16;
  localparam int ICFG_BW = 4;

  typedef logic [VDIM-1:0][WORK_BW-1:0] ofs_vec_t;

endpackage

// File: rtl/accum_offset_walker_nd_counter.sv
// ---------------------------------------------------------------------------
// accum_nd_counter: combinational N-dimensional offset counter.
//   i_cur    - current offset tuple
//   i_start  - per-dimension reload value (accumulation start)
//   i_last   - per-dimension inclusive last value
//   i_inc    - advance the counter by one step
//   o_next   - next offset tuple (equals i_cur when i_inc is low)
//   o_islast - every dimension sits at its last value
// Dimension DIM-1 moves fastest. A dimension at its last value reloads its
// start value and carries into the next outer dimension, so no dimension
// ever increments past i_last (no wrap even when last is all-ones).
// ---------------------------------------------------------------------------
module accum_nd_counter #(
  parameter int DIM = 2,
  parameter int WBW = 16
) (
  input  logic [DIM-1:0][WBW-1:0] i_cur,
  input  logic [DIM-1:0][WBW-1:0] i_start,
  input  logic [DIM-1:0][WBW-1:0] i_last,
  input  logic                    i_inc,
  output logic [DIM-1:0][WBW-1:0] o_next,
  output logic                    o_islast
);

  // carry[d] is the increment request arriving at dimension d-1 from d.
  logic [DIM:1]   carry;
  logic [DIM-1:0] at_last;

  assign carry[DIM] = i_inc;

  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_dim
      assign at_last[gi] = (i_cur[gi] == i_last[gi]);
      assign o_next[gi]  = !carry[gi+1] ? i_cur[gi] :
                           (at_last[gi] ? i_start[gi] : i_cur[gi] + WBW'(1));
      if (gi > 0) begin : g_carry
        assign carry[gi] = carry[gi+1] & at_last[gi];
      end
    end
  endgenerate

  assign o_islast = &at_last;

endmodule

// File: rtl/accum_offset_walker.sv
// ---------------------------------------------------------------------------
// accum_offset_walker: consumer of the accumulation-block offset handshake.
// Accepts one block descriptor at a time and emits every N-D accumulation
// offset from start to last inclusive (innermost dimension fastest), one per
// downstream handshake, then pulses blkdone_dval.
//
// Ports
//   i_clk, i_rst         - clock, synchronous active-low reset
//   abofs_rdy/abofs_ack  - descriptor handshake (ack is combinational)
//   i_bofs,i_aofs,i_alast- block offset, accum start, accum last (inclusive)
//   i_beg, i_end         - config index range [beg, end)
//   dst_rdy/dst_ack      - offset tuple handshake
//   o_bofs,o_aofs        - registered block offset, current accum offset
//   o_beg, o_end         - registered config range
//   o_islast             - current tuple is the final one of the block
//   blkdone_dval         - one-cycle pulse when a block finishes
//
// Build option: define ACCUM_WALKER_PREFETCH_EN to add a one-entry
// descriptor slot so back-to-back blocks stream without a bubble.
// ---------------------------------------------------------------------------
module accum_offset_walker
  import TauCfg::*;
#(
  parameter int DIM    = VDIM,
  parameter int WBW    = WORK_BW,
  parameter int CFG_BW = ICFG_BW
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    abofs_rdy,
  output logic                    abofs_ack,
  input  logic [DIM-1:0][WBW-1:0] i_bofs,
  input  logic [DIM-1:0][WBW-1:0] i_aofs,
  input  logic [DIM-1:0][WBW-1:0] i_alast,
  input  logic [CFG_BW-1:0]       i_beg,
  input  logic [CFG_BW-1:0]       i_end,
  output logic                    dst_rdy,
  input  logic                    dst_ack,
  output logic [DIM-1:0][WBW-1:0] o_bofs,
  output logic [DIM-1:0][WBW-1:0] o_aofs,
  output logic [CFG_BW-1:0]       o_beg,
  output logic [CFG_BW-1:0]       o_end,
  output logic                    o_islast,
  output logic                    blkdone_dval
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WALK = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [DIM-1:0][WBW-1:0] bofs_q, bofs_d;
  logic [DIM-1:0][WBW-1:0] aofs_q, aofs_d;
  logic [DIM-1:0][WBW-1:0] alast_q, alast_d;
  logic [DIM-1:0][WBW-1:0] cur_q, cur_d;
  logic [CFG_BW-1:0]       beg_q, beg_d;
  logic [CFG_BW-1:0]       end_q, end_d;
  logic                    done_q, done_d;

  logic                    walking;
  logic                    step;
  logic                    fin;
  logic                    abofs_xfer;
  logic                    load;
  logic [DIM-1:0][WBW-1:0] cnt_next;
  logic                    cnt_islast;

  // Next descriptor candidate: slot contents if present, else the input.
  logic                    nd_avail;
  logic                    nd_empty;
  logic [DIM-1:0][WBW-1:0] nd_bofs, nd_aofs, nd_alast;
  logic [CFG_BW-1:0]       nd_beg, nd_end;

  assign walking    = (state_q == ST_WALK);
  assign step       = walking && dst_ack && !cnt_islast;
  assign fin        = walking && dst_ack && cnt_islast;
  assign abofs_xfer = abofs_rdy && abofs_ack;

  accum_nd_counter #(
    .DIM (DIM),
    .WBW (WBW)
  ) u_cnt (
    .i_cur    (cur_q),
    .i_start  (aofs_q),
    .i_last   (alast_q),
    .i_inc    (step),
    .o_next   (cnt_next),
    .o_islast (cnt_islast)
  );

`ifdef ACCUM_WALKER_PREFETCH_EN
  logic                    slot_vld_q, slot_vld_d;
  logic [DIM-1:0][WBW-1:0] slot_bofs_q, slot_bofs_d;
  logic [DIM-1:0][WBW-1:0] slot_aofs_q, slot_aofs_d;
  logic [DIM-1:0][WBW-1:0] slot_alast_q, slot_alast_d;
  logic [CFG_BW-1:0]       slot_beg_q, slot_beg_d;
  logic [CFG_BW-1:0]       slot_end_q, slot_end_d;

  // Ack is gated by reset so nothing is accepted that would be discarded.
  assign abofs_ack = abofs_rdy && i_rst && !slot_vld_q;

  assign nd_avail = slot_vld_q || abofs_xfer;
  assign nd_bofs  = slot_vld_q ? slot_bofs_q  : i_bofs;
  assign nd_aofs  = slot_vld_q ? slot_aofs_q  : i_aofs;
  assign nd_alast = slot_vld_q ? slot_alast_q : i_alast;
  assign nd_beg   = slot_vld_q ? slot_beg_q   : i_beg;
  assign nd_end   = slot_vld_q ? slot_end_q   : i_end;

  // The slot keeps whatever the walker did not consume this cycle. An
  // empty-range descriptor arriving at a block end is parked here and
  // dropped from IDLE one cycle later so its done pulse follows the
  // previous block's pulse.
  always_comb begin
    slot_vld_d   = slot_vld_q;
    slot_bofs_d  = slot_bofs_q;
    slot_aofs_d  = slot_aofs_q;
    slot_alast_d = slot_alast_q;
    slot_beg_d   = slot_beg_q;
    slot_end_d   = slot_end_q;
    if (slot_vld_q) begin
      if (load) slot_vld_d = 1'b0;
    end else if (abofs_xfer && !load) begin
      slot_vld_d   = 1'b1;
      slot_bofs_d  = i_bofs;
      slot_aofs_d  = i_aofs;
      slot_alast_d = i_alast;
      slot_beg_d   = i_beg;
      slot_end_d   = i_end;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      slot_vld_q   <= 1'b0;
      slot_bofs_q  <= '0;
      slot_aofs_q  <= '0;
      slot_alast_q <= '0;
      slot_beg_q   <= '0;
      slot_end_q   <= '0;
    end else begin
      slot_vld_q   <= slot_vld_d;
      slot_bofs_q  <= slot_bofs_d;
      slot_aofs_q  <= slot_aofs_d;
      slot_alast_q <= slot_alast_d;
      slot_beg_q   <= slot_beg_d;
      slot_end_q   <= slot_end_d;
    end
  end
`else
  assign abofs_ack = abofs_rdy && i_rst && !walking;

  assign nd_avail = abofs_xfer;
  assign nd_bofs  = i_bofs;
  assign nd_aofs  = i_aofs;
  assign nd_alast = i_alast;
  assign nd_beg   = i_beg;
  assign nd_end   = i_end;
`endif

  // A block is empty when any dimension's last lies below its start.
  always_comb begin
    nd_empty = 1'b0;
    for (int d = 0; d < DIM; d++) begin
      if (nd_alast[d] < nd_aofs[d]) nd_empty = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    bofs_d  = bofs_q;
    aofs_d  = aofs_q;
    alast_d = alast_q;
    beg_d   = beg_q;
    end_d   = end_q;
    cur_d   = cnt_next;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (nd_avail) begin
          load = 1'b1;
          if (nd_empty) done_d = 1'b1;
          else          state_d = ST_WALK;
        end
      end
      default: begin
        if (fin) begin
          done_d = 1'b1;
          // Chain straight into the next block when one is ready.
          if (nd_avail && !nd_empty) load = 1'b1;
          else                       state_d = ST_IDLE;
        end
      end
    endcase

    if (load) begin
      bofs_d  = nd_bofs;
      aofs_d  = nd_aofs;
      alast_d = nd_alast;
      beg_d   = nd_beg;
      end_d   = nd_end;
      cur_d   = nd_aofs;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      bofs_q  <= '0;
      aofs_q  <= '0;
      alast_q <= '0;
      cur_q   <= '0;
      beg_q   <= '0;
      end_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bofs_q  <= bofs_d;
      aofs_q  <= aofs_d;
      alast_q <= alast_d;
      cur_q   <= cur_d;
      beg_q   <= beg_d;
      end_q   <= end_d;
      done_q  <= done_d;
    end
  end

  assign dst_rdy      = walking;
  assign o_islast     = walking && cnt_islast;
  assign o_bofs       = bofs_q;
  assign o_aofs       = cur_q;
  assign o_beg        = beg_q;
  assign o_end        = end_q;
  assign blkdone_dval = done_q;

endmodule
